// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transceiver: parity modes,
// FSM state encodings and the minimum usable baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam int DIV_MIN = 4;

  // Parity bit for a payload whose XOR-reduction is data_xor.
  function automatic logic parity_bit(input logic data_xor, input parity_e mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: the first interval is first_cnt cycles, every
// following interval is period cycles; tick pulses in the last cycle of each.
module uart_bit_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 halt,
  input  logic [DIV_WIDTH-1:0] first_cnt,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_reg;
  logic [DIV_WIDTH-1:0] period_reg;
  logic                 run_reg;

  assign tick = run_reg && (cnt_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      period_reg <= '0;
      run_reg    <= 1'b0;
    end else if (load) begin
      cnt_reg    <= first_cnt - DIV_WIDTH'(1);
      period_reg <= period;
      run_reg    <= 1'b1;
    end else if (halt) begin
      run_reg <= 1'b0;
    end else if (tick) begin
      cnt_reg <= period_reg - DIV_WIDTH'(1);
    end else if (run_reg) begin
      cnt_reg <= cnt_reg - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with configurable width, parity and stop bits,
// valid/ready handshakes in both directions and RX error reporting.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 ser_tx,
  input  logic                 ser_rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  input  logic                 err_clear
);

  localparam parity_e              PAR_MODE  = parity_e'(2'(PARITY));
  localparam logic [3:0]           BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(DIV_MIN);

  logic [DIV_WIDTH-1:0] div_eff;
  assign div_eff = (baud_div < DIV_FLOOR) ? DIV_FLOOR : baud_div;

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_reg, tx_state_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_par_reg, tx_par_next;
  logic [3:0]           tx_bit_reg, tx_bit_next;
  logic                 tx_stop_reg, tx_stop_next;
  logic                 ser_tx_reg, ser_tx_next;
  logic                 tx_load, tx_halt, tx_tick;

  uart_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_tx_timer (
    .clk(wb_clk_i), .rst(wb_rst_i), .load(tx_load), .halt(tx_halt),
    .first_cnt(div_eff), .period(div_eff), .tick(tx_tick)
  );

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    tx_bit_next   = tx_bit_reg;
    tx_stop_next  = tx_stop_reg;
    tx_load       = 1'b0;
    tx_halt       = 1'b0;
    case (tx_state_reg)
      TX_IDLE: if (tx_valid) begin
        tx_load       = 1'b1;
        tx_shift_next = tx_data;
        tx_par_next   = parity_bit(^tx_data, PAR_MODE);
        tx_bit_next   = '0;
        tx_stop_next  = 1'b0;
        tx_state_next = TX_START;
      end
      TX_START: if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA: if (tx_tick) begin
        tx_shift_next = tx_shift_reg >> 1;
        tx_bit_next   = tx_bit_reg + 4'd1;
        if (tx_bit_reg == BIT_LAST)
          tx_state_next = (PAR_MODE == PAR_NONE) ? TX_STOP : TX_PAR;
      end
      TX_PAR: if (tx_tick) tx_state_next = TX_STOP;
      TX_STOP: if (tx_tick) begin
        if (tx_stop_reg == STOP_LAST) begin
          tx_halt       = 1'b1;
          tx_state_next = TX_IDLE;
        end else begin
          tx_stop_next = 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // ser_tx is registered from the next state so the pin never glitches.
  always_comb begin
    case (tx_state_next)
      TX_START: ser_tx_next = 1'b0;
      TX_DATA:  ser_tx_next = tx_shift_next[0];
      TX_PAR:   ser_tx_next = tx_par_next;
      default:  ser_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_bit_reg   <= '0;
      tx_stop_reg  <= 1'b0;
      ser_tx_reg   <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      tx_bit_reg   <= tx_bit_next;
      tx_stop_reg  <= tx_stop_next;
      ser_tx_reg   <= ser_tx_next;
    end
  end

  assign tx_ready = (tx_state_reg == TX_IDLE);
  assign tx_busy  = !tx_ready;
  assign ser_tx   = ser_tx_reg;

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync_reg;
  logic                 rx_in;
  rx_state_e            rx_state_reg, rx_state_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic [3:0]           rx_bit_reg, rx_bit_next;
  logic                 rx_perr_reg, rx_perr_next;
  logic                 rx_load, rx_halt, rx_tick, rx_deliver;
  logic                 rx_valid_reg, rx_ferr_reg, rx_pflag_reg, rx_overrun_reg;
  logic [DATA_BITS-1:0] rx_data_reg;

  assign rx_in = rx_sync_reg[1];

  uart_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_rx_timer (
    .clk(wb_clk_i), .rst(wb_rst_i), .load(rx_load), .halt(rx_halt),
    .first_cnt(div_eff >> 1), .period(div_eff), .tick(rx_tick)
  );

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_shift_next = rx_shift_reg;
    rx_bit_next   = rx_bit_reg;
    rx_perr_next  = rx_perr_reg;
    rx_load       = 1'b0;
    rx_halt       = 1'b0;
    rx_deliver    = 1'b0;
    case (rx_state_reg)
      RX_IDLE: if (!rx_in) begin
        rx_load       = 1'b1;
        rx_state_next = RX_START;
      end
      RX_START: if (rx_tick) begin
        if (rx_in) begin
          rx_halt       = 1'b1;
          rx_state_next = RX_IDLE;
        end else begin
          rx_bit_next   = '0;
          rx_perr_next  = 1'b0;
          rx_state_next = RX_DATA;
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_next = {rx_in, rx_shift_reg[DATA_BITS-1:1]};
        rx_bit_next   = rx_bit_reg + 4'd1;
        if (rx_bit_reg == BIT_LAST)
          rx_state_next = (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PAR;
      end
      RX_PAR: if (rx_tick) begin
        rx_perr_next  = rx_in != parity_bit(^rx_shift_reg, PAR_MODE);
        rx_state_next = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_deliver    = 1'b1;
        rx_halt       = 1'b1;
        rx_state_next = rx_in ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_in) rx_state_next = RX_IDLE;
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_sync_reg    <= 2'b11;
      rx_state_reg   <= RX_IDLE;
      rx_shift_reg   <= '0;
      rx_bit_reg     <= '0;
      rx_perr_reg    <= 1'b0;
      rx_valid_reg   <= 1'b0;
      rx_data_reg    <= '0;
      rx_ferr_reg    <= 1'b0;
      rx_pflag_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[0], ser_rx};
      rx_state_reg <= rx_state_next;
      rx_shift_reg <= rx_shift_next;
      rx_bit_reg   <= rx_bit_next;
      rx_perr_reg  <= rx_perr_next;
      // A new byte beats a same-cycle consume, so rx_valid stays high.
      if (rx_deliver && (!rx_valid_reg || rx_ready)) begin
        rx_valid_reg <= 1'b1;
        rx_data_reg  <= rx_shift_reg;
        rx_ferr_reg  <= !rx_in;
        rx_pflag_reg <= rx_perr_reg;
      end else if (rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
      if (err_clear)
        rx_overrun_reg <= 1'b0;
      else if (rx_deliver && rx_valid_reg && !rx_ready)
        rx_overrun_reg <= 1'b1;
    end
  end

  assign rx_valid      = rx_valid_reg;
  assign rx_data       = rx_data_reg;
  assign rx_frame_err  = rx_ferr_reg;
  assign rx_parity_err = rx_pflag_reg;
  assign rx_overrun    = rx_overrun_reg;

endmodule

// File: tb/tb_uart_xcvr.sv
// Randomised self-checking bench for uart_xcvr (8 data bits, even parity,
// one stop bit, divisor 16) against a frame-level reference model.
module tb_uart_xcvr;

  localparam int DIV = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] baud_div = 16'(DIV);
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, tx_busy, ser_tx;
  logic        ser_rx;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b1;
  logic        rx_frame_err, rx_parity_err, rx_overrun;
  logic        err_clear = 1'b0;

  logic        loop_en = 1'b0;
  logic        rx_drv = 1'b1;
  assign ser_rx = loop_en ? ser_tx : rx_drv;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rx_rec_t;
  rx_rec_t rx_q[$];

  always #5 wb_clk_i = ~wb_clk_i;

  uart_xcvr #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_WIDTH(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .baud_div(baud_div),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_overrun(rx_overrun), .err_clear(err_clear)
  );

  // Scoreboard of consumed bytes, sampled mid-way between edges.
  always @(negedge wb_clk_i) begin
    #2;
    if (!wb_rst_i && rx_valid && rx_ready)
      rx_q.push_back({rx_data, rx_frame_err, rx_parity_err});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  // Frame bit k (k=0 start .. 10 stop); parity makes the count of ones even.
  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit flip, input bit stop);
    logic par;
    par = ($countones(d) % 2) == 1;
    return {stop, par ^ flip, d, 1'b0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic drive_frame(input logic [10:0] f);
    for (int b = 0; b < 11; b++) begin
      rx_drv = f[b];
      cyc(DIV);
    end
  endtask

  task automatic check_rec(input string name, input int idx, input rx_rec_t exp);
    n_cmp++;
    if (rx_q.size() <= idx) begin
      n_fail++;
      $display("FAIL %s: got %0d bytes, want at least %0d", name, rx_q.size(), idx + 1);
    end else if (rx_q[idx] !== exp) begin
      n_fail++;
      $display("FAIL %s: got data=%h ferr=%b perr=%b want data=%h ferr=%b perr=%b",
               name, rx_q[idx].data, rx_q[idx].ferr, rx_q[idx].perr, exp.data, exp.ferr, exp.perr);
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    cyc(3);
    n_cmp++;
    if ({ser_tx, tx_ready, tx_busy, rx_valid, rx_overrun, rx_frame_err, rx_parity_err} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 1100000",
               {ser_tx, tx_ready, tx_busy, rx_valid, rx_overrun, rx_frame_err, rx_parity_err});
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    wb_rst_i = 1'b0;
    cyc(2);
  endtask

  task automatic test_tx_frame(input logic [7:0] d);
    logic [10:0] f;
    logic bad, got;
    f = make_frame(d, 1'b0, 1'b1);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_ready_idle: got %b want 1", tx_ready);
    end
    tx_data = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    for (int b = 0; b < 11; b++) begin
      bad = 1'b0;
      got = f[b];
      for (int j = 0; j < DIV; j++) begin
        if (ser_tx !== f[b] || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
          bad = 1'b1;
          got = ser_tx;
        end
        cyc(1);
      end
      n_cmp++;
      if (bad) begin
        n_fail++;
        $display("FAIL tx_%h_bit%0d: got ser_tx=%b busy=%b want ser_tx=%b busy=1", d, b, got, tx_busy, f[b]);
      end
    end
    n_cmp++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_%h_end: got ready=%b busy=%b want ready=1 busy=0 at 176 cycles", d, tx_ready, tx_busy);
    end
    $display("tx frame %h checked", d);
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    int n;
    rx_q.delete();
    loop_en = 1'b1;
    rx_ready = 1'b1;
    cyc(2);
    tx_data = a;
    tx_valid = 1'b1;
    cyc(1);
    tx_data = b;
    n = 0;
    while (tx_ready !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    n_cmp++;
    if (n != 176) begin
      n_fail++;
      $display("FAIL b2b_ready_time: got %0d cycles want 176", n);
    end
    cyc(1);
    tx_valid = 1'b0;
    n_cmp++;
    if (ser_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_start: got ser_tx=%b want 0", ser_tx);
    end
    cyc(400);
    n_cmp++;
    if (rx_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d bytes want 2", rx_q.size());
    end
    check_rec("b2b_first", 0, {a, 1'b0, 1'b0});
    check_rec("b2b_second", 1, {b, 1'b0, 1'b0});
    n_cmp++;
    if (rx_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %b want 0", rx_overrun);
    end
    loop_en = 1'b0;
    $display("loopback %h %h checked", a, b);
  endtask

  task automatic test_frame_err(input logic [7:0] d);
    rx_q.delete();
    rx_ready = 1'b1;
    drive_frame(make_frame(8'h55, 1'b0, 1'b0));
    cyc(64);
    check_rec("ferr_byte", 0, {8'h55, 1'b1, 1'b0});
    rx_drv = 1'b1;
    cyc(200);
    n_cmp++;
    if (rx_q.size() != 1) begin
      n_fail++;
      $display("FAIL ferr_no_rearm: got %0d bytes want 1", rx_q.size());
    end
    drive_frame(make_frame(d, 1'b0, 1'b1));
    cyc(20);
    check_rec("ferr_recover", 1, {d, 1'b0, 1'b0});
    $display("frame error then %h checked", d);
  endtask

  task automatic test_overrun(input logic [7:0] a, input logic [7:0] b);
    rx_q.delete();
    rx_ready = 1'b0;
    drive_frame(make_frame(a, 1'b0, 1'b1));
    cyc(8);
    drive_frame(make_frame(b, 1'b0, 1'b1));
    cyc(20);
    n_cmp++;
    if ({rx_valid, rx_data, rx_overrun} !== {1'b1, a, 1'b1}) begin
      n_fail++;
      $display("FAIL overrun_hold: got valid=%b data=%h ovr=%b want valid=1 data=%h ovr=1",
               rx_valid, rx_data, rx_overrun, a);
    end
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    n_cmp++;
    if ({rx_valid, rx_data, rx_overrun} !== {1'b1, a, 1'b0}) begin
      n_fail++;
      $display("FAIL overrun_clear: got valid=%b data=%h ovr=%b want valid=1 data=%h ovr=0",
               rx_valid, rx_data, rx_overrun, a);
    end
    rx_ready = 1'b1;
    cyc(2);
    n_cmp++;
    if (rx_q.size() != 1 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_drain: got %0d bytes valid=%b want 1 byte valid=0", rx_q.size(), rx_valid);
    end
    check_rec("overrun_kept", 0, {a, 1'b0, 1'b0});
    $display("overrun %h kept %h dropped checked", a, b);
  endtask

  task automatic test_glitch(input logic [7:0] d);
    rx_q.delete();
    rx_ready = 1'b1;
    rx_drv = 1'b0;
    cyc(4);
    rx_drv = 1'b1;
    cyc(100);
    n_cmp++;
    if (rx_q.size() != 0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_ignored: got %0d bytes valid=%b want 0 bytes", rx_q.size(), rx_valid);
    end
    drive_frame(make_frame(d, 1'b0, 1'b1));
    cyc(20);
    check_rec("glitch_recover", 0, {d, 1'b0, 1'b0});
    $display("glitch then %h checked", d);
  endtask

  task automatic test_parity(input logic [7:0] d, input bit flip);
    rx_q.delete();
    rx_ready = 1'b1;
    drive_frame(make_frame(d, flip, 1'b1));
    cyc(20);
    check_rec("parity", 0, {d, 1'b0, flip});
    $display("parity frame %h flip=%0d checked", d, flip);
  endtask

  task automatic test_reset_mid(input logic [7:0] d, input int at_cycle);
    logic [10:0] f;
    f = make_frame(d, 1'b0, 1'b1);
    tx_data = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    cyc(at_cycle);
    n_cmp++;
    if (ser_tx !== f[at_cycle / DIV]) begin
      n_fail++;
      $display("FAIL rstmid_before: got ser_tx=%b want %b", ser_tx, f[at_cycle / DIV]);
    end
    wb_rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({ser_tx, tx_ready, tx_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL rstmid_async: got tx/ready/busy=%b want 110", {ser_tx, tx_ready, tx_busy});
    end
    cyc(3);
    wb_rst_i = 1'b0;
    cyc(2);
    n_cmp++;
    if ({ser_tx, tx_ready, rx_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL rstmid_release: got tx/ready/rxv=%b want 110", {ser_tx, tx_ready, rx_valid});
    end
    $display("reset at tx cycle %0d checked", at_cycle);
    test_tx_frame(8'h3D);
  endtask

  initial begin
    test_reset();
    test_tx_frame(8'h3D);
    for (int i = 0; i < 3; i++) test_tx_frame(8'($urandom));
    test_back_to_back(8'h0F, 8'hA5);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_frame_err(8'($urandom));
    test_overrun(8'($urandom), 8'($urandom));
    test_glitch(8'($urandom));
    test_parity(8'($urandom), 1'b1);
    test_parity(8'($urandom), 1'b0);
    test_reset_mid(8'h3D, 4 * DIV + 6);
    test_reset_mid(8'($urandom), 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
# uart_xcvr

- Synthesizable full-duplex UART transceiver for the user-project area. It is the parametrised successor to the fixed 8N1 testbench UART.
- Configurable in data width, parity and stop bits, with a run-time baud divisor.
- Provides a valid/ready byte handshake on both directions, plus framing-error, parity-error and overrun reporting.
- Sits between the Wishbone register slice and the mprj_io UART pins (TX on io[6], RX on io[5]).

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame (5..9), sent LSB first
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks only the first
- DIV_WIDTH, 16, width of baud_div

Ports:
- wb_clk_i  in  1  single clock for the whole block
- wb_rst_i  in  1  reset, asynchronous, active-high
- baud_div  in  DIV_WIDTH  clock cycles per bit; values below 4 behave as 4
- tx_valid  in  1  TX byte offered
- tx_data  in  DATA_BITS  TX payload
- tx_ready  out  1  TX accepts a byte this cycle
- tx_busy  out  1  frame in flight on ser_tx
- ser_tx  out  1  serial output, idle high
- ser_rx  in  1  serial input, asynchronous
- rx_valid  out  1  received byte held
- rx_data  out  DATA_BITS  received payload
- rx_ready  in  1  consumer takes the byte
- rx_frame_err  out  1  first stop bit sampled low; qualified by rx_valid
- rx_parity_err  out  1  parity mismatch; qualified by rx_valid; always 0 when PARITY = 0
- rx_overrun  out  1  sticky; a completed frame was dropped
- err_clear  in  1  clears rx_overrun

## Operation
TX FSM: TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP.
- tx_ready = (state == TX_IDLE).
- Handshake when tx_valid && tx_ready: latch tx_data, latch baud_div, go to TX_START.
- Each bit is driven for exactly the latched divisor count.
- TX_PAR is skipped when PARITY = 0.
- TX_STOP lasts STOP_BITS bit times, then returns to TX_IDLE.
- tx_busy = !tx_ready.

RX path: two-FF synchronizer, then an FSM with states RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH.
- RX_IDLE: synced ser_rx low latches baud_div and enters RX_START.
- RX_START: waits divisor/2 cycles (integer), then samples. If the sample is high it is a glitch: return to RX_IDLE with no output.
- Subsequent samples are taken every divisor cycles (bit centres), for data, then parity, then the first stop bit.
- After the stop sample, delivery happens as follows:
  - Holding register empty, or rx_ready high this cycle: load rx_data and both error flags, set rx_valid.
  - Otherwise: drop the frame and set rx_overrun.
- Next state after the stop sample:
  - Stop bit high: RX_IDLE.
  - Stop bit low (frame error or break): RX_WAIT_HIGH, which rearms only when synced ser_rx is high.
- rx_valid clears on rx_ready when no new byte is loaded in the same cycle. Simultaneous consume and load: the new byte wins and rx_valid stays high.
- err_clear has priority over a same-cycle overrun set.

## Timing
- Reset (async, all outputs): ser_tx = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, rx_data = 0, all error flags = 0, synchronizer FFs = 1, both FSMs idle.
- TX latency: ser_tx falls in the cycle after the handshake.
- TX frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × div cycles. tx_ready rises the cycle after the last stop cycle.
- Back-to-back TX: a handshake in the first tx_ready cycle produces no idle gap.
- RX sample point: div/2 + k·div cycles after the synchronized falling edge, where k = 0 for start, 1..DATA_BITS for data, then parity, then stop. Synchronized edge = pin edge + 2 cycles.
- rx_valid rises 1 cycle after the stop sample.
- A baud_div change mid-frame takes effect on the next frame only.
- wb_rst_i asserted mid-frame forces reset values immediately. No partial byte is ever delivered.

## Structure
- uart_pkg: parity enum (PAR_NONE, PAR_EVEN, PAR_ODD), TX and RX state enums, DIV_MIN = 4.
- Sub-module uart_bit_timer: a counter loaded with (div or div/2) that pulses tick on expiry. Instantiated once in TX and once in RX.
- Top level uart_xcvr holds both FSMs, the shift registers and the synchronizer.

## Test plan
Unless noted: DATA_BITS = 8, PARITY = 1 (even), STOP_BITS = 1, baud_div = 16.
- TX 0x3D → ser_tx produces 0, 1,0,1,1,1,1,0,0, parity 1, stop 1, each bit held 16 cycles. tx_ready returns 176 cycles after ser_tx falls.
- Loopback ser_tx→ser_rx, send 0x0F then 0xA5 back-to-back → rx_valid twice, data 0x0F then 0xA5, no errors, no idle gap on ser_tx.
- Drive a frame with data 0x55 and stop bit 0, then hold the line low for 64 cycles → rx_data = 0x55 with rx_frame_err = 1. No new frame is detected until the line goes high.
- Two frames with rx_ready held low → first byte retained, rx_overrun = 1, second byte dropped. A pulse on err_clear clears rx_overrun.
- 4-cycle low glitch on ser_rx → no rx_valid and RX returns to idle. A parity-flipped frame → rx_parity_err = 1.
- Assert wb_rst_i during TX data bit 3 → ser_tx = 1 asynchronously, tx_ready = 1 after release, next transmit of 0x3D is correct.
